multi_dataflow_tcdm_xbar: RTL



---
 rtl/multi_dataflow_pkg.sv | 21 ++
 rtl/multi_dataflow_rr_arb.sv | 44 ++++
 rtl/multi_dataflow_tcdm_xbar.sv | 115 +++++++++++
 3 files changed

// File: rtl/multi_dataflow_pkg.sv
// Shared types and helpers for the multi_dataflow TCDM interconnect.
// Request fields are bundled so each bank can mux a whole port request at once.
package multi_dataflow_pkg;

  localparam int unsigned TCDM_DATA_W    = 32;
  localparam int unsigned TCDM_BE_W      = 4;
  // Rows wider than any supported bank depth; the top truncates to BANK_ADDR_W.
  localparam int unsigned TCDM_ROW_W_MAX = 16;

  function automatic int unsigned bank_idx_w(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  typedef struct packed {
    logic                      wen;
    logic [TCDM_BE_W-1:0]      be;
    logic [TCDM_ROW_W_MAX-1:0] row;
    logic [TCDM_DATA_W-1:0]    data;
  } tcdm_req_t;

endpackage

// File: rtl/multi_dataflow_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating pointer,
// pointer moves just past the winner and holds when nobody requests.
module multi_dataflow_rr_arb #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q;
  logic          found;
  int unsigned   j;

  // NOTE: every always_comb output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/multi_dataflow_tcdm_xbar.sv
// Word-interleaved log interconnect from MP HWPE master ports onto NB 1-cycle SRAM banks,
// with a round-robin arbiter per bank and a one-cycle response path back to each port.
module multi_dataflow_tcdm_xbar
  import multi_dataflow_pkg::*;
#(
  parameter int unsigned MP          = 4,
  parameter int unsigned NB          = 8,
  parameter int unsigned BANK_ADDR_W = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [MP-1:0]                   tcdm_req,
  output logic [MP-1:0]                   tcdm_gnt,
  input  logic [MP-1:0][31:0]             tcdm_add,
  input  logic [MP-1:0]                   tcdm_wen,
  input  logic [MP-1:0][3:0]              tcdm_be,
  input  logic [MP-1:0][31:0]             tcdm_data,
  output logic [MP-1:0][31:0]             tcdm_r_data,
  output logic [MP-1:0]                   tcdm_r_valid,
  output logic [NB-1:0]                   bank_req_o,
  output logic [NB-1:0]                   bank_wen_o,
  output logic [NB-1:0][BANK_ADDR_W-1:0]  bank_addr_o,
  output logic [NB-1:0][3:0]              bank_be_o,
  output logic [NB-1:0][31:0]             bank_wdata_o,
  input  logic [NB-1:0][31:0]             bank_rdata_i
);

  localparam int unsigned BW = bank_idx_w(NB);
  localparam int unsigned IW = (MP > 1) ? $clog2(MP) : 1;

  logic      [MP-1:0][BW-1:0] port_bank;
  tcdm_req_t [MP-1:0]         port_fields;
  logic      [NB-1:0][MP-1:0] arb_req;
  logic      [NB-1:0][MP-1:0] arb_gnt;
  logic      [NB-1:0][IW-1:0] arb_idx;

  logic [MP-1:0]         resp_vld_q;
  logic [MP-1:0][BW-1:0] resp_bank_q;
  logic [MP-1:0]         resp_rd_q;

  // Decode: byte offset dropped, low word bits pick the bank, bits above alias.
  always_comb begin
    port_bank   = '0;
    port_fields = '0;
    arb_req     = '0;
    for (int unsigned k = 0; k < MP; k++) begin
      port_bank[k]        = tcdm_add[k][2 +: BW];
      port_fields[k].wen  = tcdm_wen[k];
      port_fields[k].be   = tcdm_be[k];
      port_fields[k].row  = TCDM_ROW_W_MAX'(tcdm_add[k][2 + BW +: BANK_ADDR_W]);
      port_fields[k].data = tcdm_data[k];
      for (int unsigned b = 0; b < NB; b++) begin
        arb_req[b][k] = tcdm_req[k] && (port_bank[k] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank_arb
    multi_dataflow_rr_arb #(.N(MP)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (arb_req[b]),
      .gnt    (arb_gnt[b]),
      .idx    (arb_idx[b])
    );
  end

  // Bank field mux; idle banks see all-zero fields.
  always_comb begin
    tcdm_req_t sel;
    sel          = '0;
    bank_req_o   = '0;
    bank_wen_o   = '0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    tcdm_gnt     = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      bank_req_o[b] = |arb_gnt[b];
      sel           = port_fields[arb_idx[b]];
      if (bank_req_o[b]) begin
        bank_wen_o[b]   = sel.wen;
        bank_addr_o[b]  = sel.row[BANK_ADDR_W-1:0];
        bank_be_o[b]    = sel.be;
        bank_wdata_o[b] = sel.data;
      end
      tcdm_gnt = tcdm_gnt | arb_gnt[b];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_vld_q  <= '0;
      resp_bank_q <= '0;
      resp_rd_q   <= '0;
    end else begin
      resp_vld_q <= tcdm_gnt;
      for (int unsigned k = 0; k < MP; k++) begin
        if (tcdm_gnt[k]) begin
          resp_bank_q[k] <= port_bank[k];
          resp_rd_q[k]   <= tcdm_wen[k];
        end
      end
    end
  end

  always_comb begin
    tcdm_r_valid = resp_vld_q;
    tcdm_r_data  = '0;
    for (int unsigned k = 0; k < MP; k++) begin
      if (resp_vld_q[k] && resp_rd_q[k]) tcdm_r_data[k] = bank_rdata_i[resp_bank_q[k]];
    end
  end

endmodule
